// File: rtl/pc_unit.sv
// pc_unit: program counter with stall-tolerant redirect latch, trap entry and
// misaligned-target rejection. Rev 1.0
`default_nettype none

module pc_unit #(
  parameter int          XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter logic [XLEN-1:0] STEP         = XLEN'(4)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] opr_res_i,
  input  logic            trap_i,
  input  logic            trap_ret_i,
  input  logic [XLEN-1:0] epc_in_i,
  output logic [XLEN-1:0] pc_out_o,
  output logic [XLEN-1:0] pc_plus_step_o,
  output logic            redirect_pending_o,
  output logic            misaligned_o,
  output logic [XLEN-1:0] bad_addr_o
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] bad_q, bad_d;
  logic            mis_q, mis_d;

  logic            redir;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_bad;
  logic [XLEN-1:0] pc_inc;

  // trap_ret outranks br_taken when both request a redirect.
  assign redir     = trap_ret_i | br_taken_i;
  assign redir_tgt = trap_ret_i ? epc_in_i : opr_res_i;
  assign redir_bad = redir & (redir_tgt[1:0] != 2'b00);
  assign pc_inc    = pc_q + STEP;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    bad_d   = bad_q;
    mis_d   = 1'b0;
    if (trap_i) begin
      pc_d    = TRAP_VECTOR;
      tgt_d   = '0;
      state_d = RUN;
    end else if (redir_bad) begin
      pc_d    = TRAP_VECTOR;
      bad_d   = redir_tgt;
      mis_d   = 1'b1;
      tgt_d   = '0;
      state_d = RUN;
    end else if (redir) begin
      if (stall_i) begin
        tgt_d   = redir_tgt;
        state_d = PEND;
      end else begin
        pc_d    = redir_tgt;
        state_d = RUN;
      end
    end else if (state_q == PEND) begin
      if (!stall_i) begin
        pc_d    = tgt_q;
        state_d = RUN;
      end
    end else if (!stall_i) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= '0;
      bad_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      bad_q   <= bad_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_out_o           = pc_q;
  assign pc_plus_step_o     = pc_inc;
  assign redirect_pending_o = (state_q == PEND);
  assign misaligned_o       = mis_q;
  assign bad_addr_o         = bad_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit. Rev 1.0
`default_nettype none

module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] opr_res_i;
  logic        trap_i;
  logic        trap_ret_i;
  logic [31:0] epc_in_i;
  logic [31:0] pc_out_o;
  logic [31:0] pc_plus_step_o;
  logic        redirect_pending_o;
  logic        misaligned_o;
  logic [31:0] bad_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit dut (
    .clk                (clk),
    .rst                (rst),
    .stall_i            (stall_i),
    .br_taken_i         (br_taken_i),
    .opr_res_i          (opr_res_i),
    .trap_i             (trap_i),
    .trap_ret_i         (trap_ret_i),
    .epc_in_i           (epc_in_i),
    .pc_out_o           (pc_out_o),
    .pc_plus_step_o     (pc_plus_step_o),
    .redirect_pending_o (redirect_pending_o),
    .misaligned_o       (misaligned_o),
    .bad_addr_o         (bad_addr_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] pc, input logic pend,
                     input logic mis);
    check({tag, ".pc"}, pc_out_o, pc);
    check({tag, ".pend"}, {31'd0, redirect_pending_o}, {31'd0, pend});
    check({tag, ".mis"}, {31'd0, misaligned_o}, {31'd0, mis});
  endtask

  task automatic br(input logic [31:0] t);
    br_taken_i = 1'b1;
    opr_res_i  = t;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; br_taken_i = 1'b0; opr_res_i = '0;
    trap_i = 1'b0; trap_ret_i = 1'b0; epc_in_i = '0;

    // reset state
    step();
    chk("reset", 32'h0, 1'b0, 1'b0);
    check("reset.bad", bad_addr_o, 32'h0);
    rst = 1'b0;

    // free-running sequence
    step(); chk("run1", 32'h4, 1'b0, 1'b0);
    step(); chk("run2", 32'h8, 1'b0, 1'b0);
    step(); chk("run3", 32'hC, 1'b0, 1'b0);
    step(); chk("run4", 32'h10, 1'b0, 1'b0);

    // unstalled branch
    br(32'h80);
    step(); chk("br80", 32'h80, 1'b0, 1'b0);
    br_taken_i = 1'b0;
    step(); chk("br84", 32'h84, 1'b0, 1'b0);
    check("plus_step", pc_plus_step_o, 32'h88);

    // stalled branch latched in PEND, released after 3 stall cycles
    br(32'h20);
    step(); chk("br20", 32'h20, 1'b0, 1'b0);
    stall_i = 1'b1; br(32'h40);
    step(); chk("pend1", 32'h20, 1'b1, 1'b0);
    br_taken_i = 1'b0;
    step(); chk("pend2", 32'h20, 1'b1, 1'b0);
    step(); chk("pend3", 32'h20, 1'b1, 1'b0);
    stall_i = 1'b0;
    step(); chk("release", 32'h40, 1'b0, 1'b0);
    step(); chk("after_rel", 32'h44, 1'b0, 1'b0);

    // new redirect at stall release beats the latched target
    stall_i = 1'b1; br(32'h40);
    step(); chk("pend_40", 32'h44, 1'b1, 1'b0);
    stall_i = 1'b0; br(32'h60);
    step(); chk("newwins", 32'h60, 1'b0, 1'b0);
    br_taken_i = 1'b0;
    step(); chk("newwins2", 32'h64, 1'b0, 1'b0);

    // overwrite of the latched target while stalled
    stall_i = 1'b1; br(32'h200);
    step(); chk("ovw1", 32'h64, 1'b1, 1'b0);
    br(32'h300);
    step(); chk("ovw2", 32'h64, 1'b1, 1'b0);
    br_taken_i = 1'b0;
    step(); chk("ovw3", 32'h64, 1'b1, 1'b0);
    stall_i = 1'b0;
    step(); chk("ovw_rel", 32'h300, 1'b0, 1'b0);

    // misaligned branch target
    br(32'h102);
    step(); chk("mis", 32'h100, 1'b0, 1'b1);
    check("mis.bad", bad_addr_o, 32'h102);
    br_taken_i = 1'b0;
    step(); chk("mis_after", 32'h104, 1'b0, 1'b0);
    check("mis_after.bad", bad_addr_o, 32'h102);

    // trap while a redirect is pending, with stall held
    stall_i = 1'b1; br(32'h80);
    step(); chk("trap_pend", 32'h104, 1'b1, 1'b0);
    br_taken_i = 1'b0; trap_i = 1'b1;
    step(); chk("trap", 32'h100, 1'b0, 1'b0);
    trap_i = 1'b0; stall_i = 1'b0;
    step(); chk("trap_after", 32'h104, 1'b0, 1'b0);

    // trap_ret beats br_taken
    trap_ret_i = 1'b1; epc_in_i = 32'h500; br(32'h600);
    step(); chk("tret", 32'h500, 1'b0, 1'b0);

    // back-to-back rejections keep misaligned high
    br_taken_i = 1'b0; epc_in_i = 32'h501;
    step(); chk("b2b1", 32'h100, 1'b0, 1'b1);
    check("b2b1.bad", bad_addr_o, 32'h501);
    trap_ret_i = 1'b0; br(32'h203);
    step(); chk("b2b2", 32'h100, 1'b0, 1'b1);
    check("b2b2.bad", bad_addr_o, 32'h203);
    br_taken_i = 1'b0;
    step(); chk("b2b_end", 32'h104, 1'b0, 1'b0);

    // rejection applies under stall
    stall_i = 1'b1; br(32'h7);
    step(); chk("mis_stall", 32'h100, 1'b0, 1'b1);
    check("mis_stall.bad", bad_addr_o, 32'h7);
    br_taken_i = 1'b0;
    step(); chk("mis_stall2", 32'h100, 1'b0, 1'b0);

    // wrap-around
    stall_i = 1'b0; br(32'hFFFF_FFFC);
    step(); chk("top", 32'hFFFF_FFFC, 1'b0, 1'b0);
    check("top.plus", pc_plus_step_o, 32'h0);
    br_taken_i = 1'b0;
    step(); chk("wrap", 32'h0, 1'b0, 1'b0);

    // reset overrides trap and pending redirect
    stall_i = 1'b1; br(32'h40);
    step(); chk("rst_pend", 32'h0, 1'b1, 1'b0);
    br_taken_i = 1'b0; rst = 1'b1; trap_i = 1'b1;
    step(); chk("rst_mid", 32'h0, 1'b0, 1'b0);
    check("rst_mid.bad", bad_addr_o, 32'h0);
    rst = 1'b0; trap_i = 1'b0; stall_i = 1'b0;
    step(); chk("post_rst", 32'h4, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32, width of every address port and register.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded by reset.
REQ-003 Parameter TRAP_VECTOR, default 'h100, PC value loaded on trap or misaligned redirect.
REQ-004 Parameter STEP, default 4, sequential PC increment.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  freeze sequential advance; PC holds.
REQ-008 br_taken  input  1  branch/jump redirect request.
REQ-009 opr_res  input  XLEN  branch/jump target from ALU.
REQ-010 trap  input  1  exception request; never stalled.
REQ-011 trap_ret  input  1  return-from-trap request.
REQ-012 epc_in  input  XLEN  return target for trap_ret.
REQ-013 pc_out  output  XLEN  current PC (registered).
REQ-014 pc_plus_step  output  XLEN  pc_out + STEP (combinational, mod 2^XLEN).
REQ-015 redirect_pending  output  1  high while a redirect is latched in state PEND.
REQ-016 misaligned  output  1  one-cycle pulse: rejected redirect target.
REQ-017 bad_addr  output  XLEN  last rejected target; holds until next rejection or reset.

Function
REQ-018 pc_out SHALL change only at a rising clk edge; it SHALL never change combinationally.
REQ-019 FSM states SHALL be RUN, PEND; RUN is the reset state.
REQ-020 Next-PC priority per cycle SHALL be: rst > trap > misaligned target > trap_ret > br_taken > pending redirect > stall hold > pc_out + STEP.
REQ-021 trap=1 SHALL load TRAP_VECTOR next cycle regardless of stall, clear any pending redirect, and enter RUN.
REQ-022 Misalignment: a selected trap_ret/br_taken target with bits [1:0] != 0 SHALL NOT be loaded; instead PC <= TRAP_VECTOR, misaligned=1 for exactly the following cycle, bad_addr <= target; applies even under stall.
REQ-023 trap_ret=1 and br_taken=1 together SHALL select epc_in; opr_res is discarded.
REQ-024 In RUN with stall=0, an aligned redirect SHALL load its target next cycle (one-cycle redirect latency).
REQ-025 In RUN with stall=1 and an aligned redirect, PC SHALL hold, target SHALL be latched, FSM SHALL go to PEND.
REQ-026 In PEND with stall=1, a new aligned redirect SHALL overwrite the latched target; otherwise the latch holds; PC holds.
REQ-027 In PEND with stall=0, PC SHALL load the latched target and FSM SHALL return to RUN, unless a new aligned redirect is present that cycle, which SHALL win and the latched target is discarded.
REQ-028 With no redirect, stall=1 holds PC; stall=0 loads pc_out + STEP, wrapping modulo 2^XLEN (all-ones-minus-3 + 4 -> 0 for XLEN=32).
REQ-029 redirect_pending SHALL equal (state == PEND), registered.
REQ-030 misaligned SHALL be registered; back-to-back rejections SHALL keep it high on consecutive cycles.
REQ-031 Latched target register SHALL be XLEN bits; no other storage of addresses except pc_out and bad_addr.

Reset
REQ-032 rst=1 at a clock edge SHALL set pc_out=RESET_VECTOR, state=RUN, redirect_pending=0, misaligned=0, bad_addr=0, latched target=0.
REQ-033 rst SHALL override all other inputs, including trap and a pending redirect mid-stall.
REQ-034 First cycle after rst deasserts with stall=0 SHALL load RESET_VECTOR + STEP.

Verification
REQ-035 Reset then 3 free cycles -> pc_out 0, 4, 8, 12; misaligned=0.
REQ-036 pc_out=0x10, br_taken=1, opr_res=0x80, stall=0 -> next pc_out=0x80, then 0x84.
REQ-037 pc_out=0x20, stall=1 with br_taken opr_res=0x40 for 1 cycle, stall held 3 cycles -> pc_out=0x20 and redirect_pending=1 throughout; on stall release pc_out=0x40, redirect_pending=0.
REQ-038 PEND holding 0x40, stall falls same cycle as br_taken opr_res=0x60 -> pc_out=0x60; 0x40 never appears.
REQ-039 br_taken opr_res=0x102 -> pc_out=0x100 (TRAP_VECTOR), misaligned=1 for one cycle, bad_addr=0x102; trap=1 while in PEND -> pc_out=0x100, redirect_pending=0.
REQ-040 pc_out=0xFFFF_FFFC, stall=0 -> pc_out=0x0; rst asserted during PEND -> pc_out=0, redirect_pending=0.
